pwm_voice_scheduler: RTL and testbench

- Shares the single 1K x 16 synth memory port between the CPU core and a voice-fetch engine.
- Once per sample tick, the engine reads an 8-word voice mailbox from memory and atomically loads duty/enable registers for the 8 PWM channels.
- Sits between the core's memory interface and the top-level memory pins. The PWM generators consume its registered outputs.

---
 rtl/synth_pkg.sv | 20 ++
 rtl/mem_port_arbiter.sv | 58 +++++
 rtl/pwm_voice_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_pwm_voice_scheduler.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared constants and types for the synth memory port and PWM voice scheduler.
// Mailbox words carry an enable bit and an 8-bit duty; bits [14:8] are reserved.
package synth_pkg;

   localparam int MEM_ADDR_W = 10;
   localparam int MEM_DATA_W = 16;
   localparam int NUM_PWM    = 8;
   localparam logic [MEM_ADDR_W-1:0] MAILBOX_BASE = 10'h3F0;

   localparam int EN_BIT   = 15;
   localparam int DUTY_MSB = 7;
   localparam int DUTY_W   = DUTY_MSB + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      COMMIT = 2'd2
   } sched_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Combinational owner selection for the single synth memory port.
// The wait counter bounds how long the core can starve a voice fetch.
module mem_port_arbiter
   import synth_pkg::*;
#(
   parameter int                ADDR_W    = MEM_ADDR_W,
   parameter int                IDX_W     = 3,
   parameter logic [ADDR_W-1:0] BASE_ADDR = MAILBOX_BASE,
   parameter int                MAX_WAIT  = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              fetch_active_in,
   input  logic              fetch_start_in,
   input  logic              core_req_in,
   input  logic              core_we_in,
   input  logic [ADDR_W-1:0] core_addr_in,
   input  logic [IDX_W-1:0]  voice_idx_in,
   output logic              sched_grant_out,
   output logic              core_stall_out,
   output logic [ADDR_W-1:0] mem_addr_out,
   output logic              mem_we_out
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   logic [WAIT_W-1:0] wait_q;
   logic [WAIT_W-1:0] wait_d;
   logic              core_grant;
   logic              sched_grant;

   always_comb begin
      core_grant  = ~fetch_active_in | (core_req_in & (wait_q != WAIT_W'(MAX_WAIT)));
      sched_grant = fetch_active_in & ~core_grant;

      wait_d = wait_q;
      if (fetch_start_in) begin
         wait_d = '0;
      end else if (fetch_active_in) begin
         // Only a cycle the core actually takes counts as lost.
         wait_d = sched_grant ? '0 : wait_q + WAIT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_q <= '0;
      end else begin
         wait_q <= wait_d;
      end
   end

   assign sched_grant_out = sched_grant;
   assign core_stall_out  = core_req_in & ~core_grant;
   assign mem_addr_out    = sched_grant ? (BASE_ADDR + ADDR_W'(voice_idx_in)) : core_addr_in;
   assign mem_we_out      = core_grant & core_req_in & core_we_in;

endmodule

// File: rtl/pwm_voice_scheduler.sv
// Per-sample-tick fetch of the voice mailbox into shadow registers, then an
// atomic commit of all duty/enable outputs so the PWMs never see a mixed frame.
module pwm_voice_scheduler
   import synth_pkg::*;
#(
   parameter int                NUM_VOICES = NUM_PWM,
   parameter int                ADDR_W     = MEM_ADDR_W,
   parameter int                DATA_W     = MEM_DATA_W,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = MAILBOX_BASE,
   parameter int                TICK_DIV   = 2500,
   parameter int                MAX_WAIT   = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    core_req_in,
   input  logic                    core_we_in,
   input  logic [ADDR_W-1:0]       core_addr_in,
   input  logic [DATA_W-1:0]       core_wdata_in,
   output logic [DATA_W-1:0]       core_rdata_out,
   output logic                    core_stall_out,
   output logic [ADDR_W-1:0]       mem_addr_out,
   output logic [DATA_W-1:0]       mem_wdata_out,
   output logic                    mem_we_out,
   input  logic [DATA_W-1:0]       mem_rdata_in,
   input  logic                    ovr_clr_in,
   output logic [8*NUM_VOICES-1:0] duty_out,
   output logic [NUM_VOICES-1:0]   voice_en_out,
   output logic                    frame_done_out,
   output logic                    overrun_out
);

   localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_VOICES - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   sched_state_e state_q;
   sched_state_e state_d;
   logic [TICK_W-1:0] tick_q;
   logic [TICK_W-1:0] tick_d;
   logic [IDX_W-1:0]  idx_q;
   logic [IDX_W-1:0]  idx_d;
   logic              pending_q;
   logic              pending_d;
   logic              overrun_q;
   logic              overrun_d;
   logic              frame_done_q;

   // Shadow keeps only the enable bit and duty byte of each mailbox word.
   logic [DUTY_W:0]   shadow_q [NUM_VOICES];
   logic [DUTY_W-1:0] duty_q   [NUM_VOICES];
   logic [NUM_VOICES-1:0] en_q;

   logic tick_wrap;
   logic fetch_start;
   logic fetch_active;
   logic commit;
   logic sched_grant;

   mem_port_arbiter #(
      .ADDR_W    (ADDR_W),
      .IDX_W     (IDX_W),
      .BASE_ADDR (BASE_ADDR),
      .MAX_WAIT  (MAX_WAIT)
   ) u_arb (
      .clk             (clk),
      .reset_n         (reset_n),
      .fetch_active_in (fetch_active),
      .fetch_start_in  (fetch_start),
      .core_req_in     (core_req_in),
      .core_we_in      (core_we_in),
      .core_addr_in    (core_addr_in),
      .voice_idx_in    (idx_q),
      .sched_grant_out (sched_grant),
      .core_stall_out  (core_stall_out),
      .mem_addr_out    (mem_addr_out),
      .mem_we_out      (mem_we_out)
   );

   assign tick_wrap    = (tick_q == TICK_LAST);
   assign tick_d       = tick_wrap ? '0 : tick_q + TICK_W'(1);
   assign fetch_active = (state_q == FETCH);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      fetch_start = 1'b0;
      commit      = 1'b0;
      case (state_q)
         IDLE: begin
            if (pending_q) begin
               state_d     = FETCH;
               idx_d       = '0;
               fetch_start = 1'b1;
            end
         end
         FETCH: begin
            if (sched_grant) begin
               idx_d = idx_q + IDX_W'(1);
               if (idx_q == LAST_IDX) begin
                  state_d = COMMIT;
               end
            end
         end
         COMMIT: begin
            commit  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A wrap that lands while busy or already queued keeps a single frame pending.
   always_comb begin
      pending_d = pending_q;
      if (tick_wrap) begin
         pending_d = 1'b1;
      end else if (fetch_start) begin
         pending_d = 1'b0;
      end

      overrun_d = overrun_q;
      if (tick_wrap && ((state_q != IDLE) || pending_q)) begin
         overrun_d = 1'b1;
      end else if (ovr_clr_in) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         tick_q       <= '0;
         idx_q        <= '0;
         pending_q    <= 1'b0;
         overrun_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         tick_q       <= tick_d;
         idx_q        <= idx_d;
         pending_q    <= pending_d;
         overrun_q    <= overrun_d;
         frame_done_q <= commit;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            shadow_q[i] <= '0;
            duty_q[i]   <= '0;
         end
         en_q <= '0;
      end else begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (sched_grant && (idx_q == IDX_W'(i))) begin
               shadow_q[i] <= {mem_rdata_in[EN_BIT], mem_rdata_in[DUTY_MSB:0]};
            end
            if (commit) begin
               duty_q[i] <= shadow_q[i][DUTY_W-1:0];
               en_q[i]   <= shadow_q[i][DUTY_W];
            end
         end
      end
   end

   for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice_out
      assign duty_out[8*gi +: 8] = duty_q[gi];
      assign voice_en_out[gi]    = en_q[gi];
   end

   assign core_rdata_out = mem_rdata_in;
   assign mem_wdata_out  = core_wdata_in;
   assign frame_done_out = frame_done_q;
   assign overrun_out    = overrun_q;

endmodule

// File: tb/tb_pwm_voice_scheduler.sv
// Scoreboard bench: stimulus queues hand-computed frames, a monitor checks each
// frame_done pulse; arbitration, overrun and reset are checked inline.
module tb_pwm_voice_scheduler;

   logic        clk;
   logic        reset_n;
   logic        core_req_in;
   logic        core_we_in;
   logic [9:0]  core_addr_in;
   logic [15:0] core_wdata_in;
   logic [15:0] core_rdata_out;
   logic        core_stall_out;
   logic [9:0]  mem_addr_out;
   logic [15:0] mem_wdata_out;
   logic        mem_we_out;
   logic [15:0] mem_rdata_in;
   logic        ovr_clr_in;
   logic [63:0] duty_out;
   logic [7:0]  voice_en_out;
   logic        frame_done_out;
   logic        overrun_out;

   typedef struct {
      logic [63:0] duty;
      logic [7:0]  en;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          n_vec;
   int          n_err;
   int          cyc;
   logic [15:0] mem [1024];
   logic        exp_stall;

   pwm_voice_scheduler #(
      .TICK_DIV (20),
      .MAX_WAIT (4)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .core_req_in    (core_req_in),
      .core_we_in     (core_we_in),
      .core_addr_in   (core_addr_in),
      .core_wdata_in  (core_wdata_in),
      .core_rdata_out (core_rdata_out),
      .core_stall_out (core_stall_out),
      .mem_addr_out   (mem_addr_out),
      .mem_wdata_out  (mem_wdata_out),
      .mem_we_out     (mem_we_out),
      .mem_rdata_in   (mem_rdata_in),
      .ovr_clr_in     (ovr_clr_in),
      .duty_out       (duty_out),
      .voice_en_out   (voice_en_out),
      .frame_done_out (frame_done_out),
      .overrun_out    (overrun_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata_in = mem[mem_addr_out];
   always @(posedge clk) begin
      if (mem_we_out) mem[mem_addr_out] <= mem_wdata_out;
   end

   // Cycle number: value n means edge n since reset release has happened.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int n);
      for (int i = 0; i < 400 && cyc != n; i++) @(negedge clk);
      chk("sync", 64'(cyc), 64'(n));
   endtask

   task automatic push_frame(input logic [63:0] d, input logic [7:0] e, input int c);
      exp_t x;
      x.duty = d;
      x.en   = e;
      x.cyc  = c;
      exp_q.push_back(x);
   endtask

   always @(negedge clk) begin
      if (frame_done_out) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_frame: got frame_done at cycle %0d expected none", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            $display("frame at cycle %0d duty=%h en=%h", cyc, duty_out, voice_en_out);
            chk("frame_cycle", 64'(cyc), 64'(mon_e.cyc));
            chk("frame_duty", duty_out, mon_e.duty);
            chk("frame_en", 64'(voice_en_out), 64'(mon_e.en));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      reset_n = 1'b0;
      core_req_in = 1'b0;
      core_we_in = 1'b0;
      core_addr_in = '0;
      core_wdata_in = '0;
      ovr_clr_in = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
      mem[10'h005] = 16'h1234;
      mem[10'h3F0] = 16'h80FF;
      mem[10'h3F1] = 16'h0040;
      mem[10'h3F2] = 16'h8001;
      mem[10'h3F3] = 16'h7F22;
      mem[10'h3F4] = 16'hFF55;
      mem[10'h3F5] = 16'h8000;
      mem[10'h3F6] = 16'h00AA;
      mem[10'h3F7] = 16'h0177;

      repeat (3) @(negedge clk);
      chk("rst_duty", duty_out, 64'h0);
      chk("rst_en", 64'(voice_en_out), 64'h0);
      chk("rst_done", 64'(frame_done_out), 64'h0);
      chk("rst_ovr", 64'(overrun_out), 64'h0);
      chk("rst_stall", 64'(core_stall_out), 64'h0);
      reset_n = 1'b1;

      // Frames: uncontended, contended, back-to-back queued, with mailbox write.
      push_frame(64'h77AA_0055_2201_40FF, 8'h35, 30);
      push_frame(64'h77AA_0055_2201_40FF, 8'h35, 82);
      push_frame(64'h77AA_0055_2201_40FF, 8'h35, 92);
      push_frame(64'h33AA_0055_2201_40FF, 8'hB5, 111);

      wait_cyc(30);
      chk("f1_duty0", 64'(duty_out[7:0]), 64'hFF);
      chk("f1_en0", 64'(voice_en_out[0]), 64'h1);
      chk("f1_duty1", 64'(duty_out[15:8]), 64'h40);
      chk("f1_en1", 64'(voice_en_out[1]), 64'h0);

      // Continuous core contention across one whole fetch.
      wait_cyc(40);
      core_req_in = 1'b1;
      core_addr_in = 10'h100;
      core_we_in = 1'b0;
      #1 chk("stall_idle", 64'(core_stall_out), 64'h0);
      for (int c = 41; c <= 81; c++) begin
         wait_cyc(c);
         #1;
         exp_stall = (c <= 80) && (((c - 41) % 5) == 4);
         chk("contend_stall", 64'(core_stall_out), 64'(exp_stall));
         if (exp_stall) chk("sched_addr", 64'(mem_addr_out), 64'(1008 + (c - 41) / 5));
         if (c == 59) begin
            chk("ovr_before", 64'(overrun_out), 64'h0);
            ovr_clr_in = 1'b1;
         end
         if (c == 60) begin
            chk("ovr_set_wins", 64'(overrun_out), 64'h1);
            ovr_clr_in = 1'b0;
         end
         if (c == 70) chk("ovr_sticky", 64'(overrun_out), 64'h1);
      end
      core_req_in = 1'b0;

      wait_cyc(94);
      chk("ovr_held", 64'(overrun_out), 64'h1);
      ovr_clr_in = 1'b1;
      wait_cyc(95);
      chk("ovr_cleared", 64'(overrun_out), 64'h0);
      ovr_clr_in = 1'b0;

      // Core rewrites voice 7 while the scheduler sits at index 3.
      wait_cyc(104);
      core_req_in = 1'b1;
      core_we_in = 1'b1;
      core_addr_in = 10'h3F7;
      core_wdata_in = 16'h8033;
      #1;
      chk("mbx_wr_stall", 64'(core_stall_out), 64'h0);
      chk("mbx_wr_we", 64'(mem_we_out), 64'h1);
      chk("mbx_wr_addr", 64'(mem_addr_out), 64'h3F7);
      wait_cyc(105);
      core_req_in = 1'b0;
      core_we_in = 1'b0;
      #1 chk("idx3_resume", 64'(mem_addr_out), 64'h3F3);

      // Reset mid-frame at index 5.
      wait_cyc(126);
      #1 chk("idx5_addr", 64'(mem_addr_out), 64'h3F5);
      reset_n = 1'b0;
      #1;
      chk("midrst_duty", duty_out, 64'h0);
      chk("midrst_en", 64'(voice_en_out), 64'h0);
      chk("midrst_done", 64'(frame_done_out), 64'h0);
      repeat (3) @(negedge clk);
      chk("midrst_duty_hold", duty_out, 64'h0);
      reset_n = 1'b1;
      push_frame(64'h33AA_0055_2201_40FF, 8'hB5, 30);

      wait_cyc(21);
      #1 chk("restart_idx0", 64'(mem_addr_out), 64'h3F0);
      wait_cyc(22);
      #1 chk("restart_idx1", 64'(mem_addr_out), 64'h3F1);

      // Plain core accesses while idle.
      wait_cyc(31);
      core_req_in = 1'b1;
      core_we_in = 1'b0;
      core_addr_in = 10'h005;
      #1;
      chk("rd_stall", 64'(core_stall_out), 64'h0);
      chk("rd_addr", 64'(mem_addr_out), 64'h005);
      chk("rd_data", 64'(core_rdata_out), 64'h1234);
      chk("rd_we", 64'(mem_we_out), 64'h0);
      wait_cyc(32);
      core_we_in = 1'b1;
      core_addr_in = 10'h006;
      core_wdata_in = 16'hBEEF;
      #1;
      chk("wr_we", 64'(mem_we_out), 64'h1);
      chk("wr_stall", 64'(core_stall_out), 64'h0);
      wait_cyc(33);
      core_we_in = 1'b0;
      #1 chk("wr_readback", 64'(core_rdata_out), 64'hBEEF);
      wait_cyc(34);
      core_req_in = 1'b0;

      wait_cyc(40);
      chk("frames_all_seen", 64'(exp_q.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
